// File: rtl/riscv_pkg.sv
// Shared pipeline types: ALU op encoding, operand selects and the ID/EX register payload.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RADDR_W  = 5;
    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd10;

    typedef enum logic {OPA_RS1 = 1'b0, OPA_PC  = 1'b1} opa_sel_e;
    typedef enum logic {OPB_RS2 = 1'b0, OPB_IMM = 1'b1} opb_sel_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [RADDR_W-1:0]  rs1_addr;
        logic [RADDR_W-1:0]  rs2_addr;
        logic [RADDR_W-1:0]  rd_addr;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        opa_sel_e            opa_sel;
        opb_sel_e            opb_sel;
        logic                rd_wren;
        logic                mem_rden;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, MEM/WB forwarding sources and EX-side outputs.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic                i_stall;
    logic                i_flush;
    logic                i_id_valid;
    logic [XLEN-1:0]     i_id_pc;
    logic [RADDR_W-1:0]  i_id_rs1_addr;
    logic [RADDR_W-1:0]  i_id_rs2_addr;
    logic [RADDR_W-1:0]  i_id_rd_addr;
    logic [XLEN-1:0]     i_id_rs1_data;
    logic [XLEN-1:0]     i_id_rs2_data;
    logic [XLEN-1:0]     i_id_imm;
    logic [ALU_OP_W-1:0] i_id_alu_op;
    logic                i_id_opa_sel;
    logic                i_id_opb_sel;
    logic                i_id_rd_wren;
    logic                i_id_mem_rden;
    logic [RADDR_W-1:0]  i_mem_rd_addr;
    logic                i_mem_rd_wren;
    logic [XLEN-1:0]     i_mem_data;
    logic [RADDR_W-1:0]  i_wb_rd_addr;
    logic                i_wb_rd_wren;
    logic [XLEN-1:0]     i_wb_data;

    logic [XLEN-1:0]     o_operand_a;
    logic [XLEN-1:0]     o_operand_b;
    logic [ALU_OP_W-1:0] o_alu_op;
    logic [XLEN-1:0]     o_store_data;
    logic                o_ex_valid;
    logic [XLEN-1:0]     o_ex_pc;
    logic [RADDR_W-1:0]  o_ex_rd_addr;
    logic                o_ex_rd_wren;
    logic                o_ex_mem_rden;
    logic                o_load_use_stall;

    modport master (
        output i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr,
               i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_alu_op, i_id_opa_sel, i_id_opb_sel,
               i_id_rd_wren, i_id_mem_rden, i_mem_rd_addr, i_mem_rd_wren, i_mem_data,
               i_wb_rd_addr, i_wb_rd_wren, i_wb_data,
        input  o_operand_a, o_operand_b, o_alu_op, o_store_data, o_ex_valid, o_ex_pc,
               o_ex_rd_addr, o_ex_rd_wren, o_ex_mem_rden, o_load_use_stall
    );

    modport slave (
        input  i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr,
               i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_alu_op, i_id_opa_sel, i_id_opb_sel,
               i_id_rd_wren, i_id_mem_rden, i_mem_rd_addr, i_mem_rd_wren, i_mem_data,
               i_wb_rd_addr, i_wb_rd_wren, i_wb_data,
        output o_operand_a, o_operand_b, o_alu_op, o_store_data, o_ex_valid, o_ex_pc,
               o_ex_rd_addr, o_ex_rd_wren, o_ex_mem_rden, o_load_use_stall
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand bypass select for one source register: MEM beats WB, x0 always reads zero.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [RADDR_W-1:0] src_addr,
    input  logic [XLEN-1:0]    src_data,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic               mem_rd_wren,
    input  logic [XLEN-1:0]    mem_data,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic               wb_rd_wren,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    fwd_data
);

    always_comb begin
        fwd_data = src_data;
        if (src_addr == '0) begin
            fwd_data = '0;
        end else if (mem_rd_wren && (mem_rd_addr == src_addr)) begin
            fwd_data = mem_data;
        end else if (wb_rd_wren && (wb_rd_addr == src_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble insertion and
// stall-time refresh of held operands so a producer retiring during a freeze is not lost.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    id_ex_stage_if.slave bus
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use;

    fwd_unit u_fwd_rs1 (
        .src_addr    (ex_q.rs1_addr),
        .src_data    (ex_q.rs1_data),
        .mem_rd_addr (bus.i_mem_rd_addr),
        .mem_rd_wren (bus.i_mem_rd_wren),
        .mem_data    (bus.i_mem_data),
        .wb_rd_addr  (bus.i_wb_rd_addr),
        .wb_rd_wren  (bus.i_wb_rd_wren),
        .wb_data     (bus.i_wb_data),
        .fwd_data    (fwd_rs1)
    );

    fwd_unit u_fwd_rs2 (
        .src_addr    (ex_q.rs2_addr),
        .src_data    (ex_q.rs2_data),
        .mem_rd_addr (bus.i_mem_rd_addr),
        .mem_rd_wren (bus.i_mem_rd_wren),
        .mem_data    (bus.i_mem_data),
        .wb_rd_addr  (bus.i_wb_rd_addr),
        .wb_rd_wren  (bus.i_wb_rd_wren),
        .wb_data     (bus.i_wb_data),
        .fwd_data    (fwd_rs2)
    );

    // Load in EX whose result ID needs now; a redirect makes the ID instruction moot.
    assign load_use = !bus.i_flush && ex_q.valid && ex_q.mem_rden && (ex_q.rd_addr != '0) &&
                      bus.i_id_valid && ((ex_q.rd_addr == bus.i_id_rs1_addr) ||
                                         (ex_q.rd_addr == bus.i_id_rs2_addr));

    // Next EX contents: flush > stall > load-use bubble > ID capture.
    always_comb begin
        ex_d = '0;
        if (bus.i_flush) begin
            ex_d = '0;
        end else if (bus.i_stall) begin
            ex_d          = ex_q;
            ex_d.rs1_data = fwd_rs1;
            ex_d.rs2_data = fwd_rs2;
        end else if (load_use || !bus.i_id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = bus.i_id_pc;
            ex_d.rs1_addr = bus.i_id_rs1_addr;
            ex_d.rs2_addr = bus.i_id_rs2_addr;
            ex_d.rd_addr  = bus.i_id_rd_addr;
            ex_d.rs1_data = bus.i_id_rs1_data;
            ex_d.rs2_data = bus.i_id_rs2_data;
            ex_d.imm      = bus.i_id_imm;
            ex_d.alu_op   = bus.i_id_alu_op;
            ex_d.opa_sel  = opa_sel_e'(bus.i_id_opa_sel);
            ex_d.opb_sel  = opb_sel_e'(bus.i_id_opb_sel);
            ex_d.rd_wren  = bus.i_id_rd_wren;
            ex_d.mem_rden = bus.i_id_mem_rden;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.o_operand_a      = (ex_q.opa_sel == OPA_PC)  ? ex_q.pc  : fwd_rs1;
    assign bus.o_operand_b      = (ex_q.opb_sel == OPB_IMM) ? ex_q.imm : fwd_rs2;
    assign bus.o_store_data     = fwd_rs2;
    assign bus.o_alu_op         = ex_q.alu_op;
    assign bus.o_ex_valid       = ex_q.valid;
    assign bus.o_ex_pc          = ex_q.pc;
    assign bus.o_ex_rd_addr     = ex_q.rd_addr;
    assign bus.o_ex_rd_wren     = ex_q.rd_wren;
    assign bus.o_ex_mem_rden    = ex_q.mem_rden;
    assign bus.o_load_use_stall = load_use;

endmodule
